// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding and width helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mem_arbiter_pkg;

  // Arbiter controller states (2-bit encoding).
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    RESPOND = 2'd3
  } state_t;

  // Bits needed to index n items; never returns less than 1 so a 1-bit pointer exists for n<=2.
  function automatic int log2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above the pointer, wrapping, as a one-hot grant.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to use the pick.
module mem_arbiter_rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = log2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_vld
);

  logic [2*NUM_REQ-1:0] w_req_dbl;
  logic [NUM_REQ-1:0]   w_req_rot;
  logic [NUM_REQ-1:0]   w_oh_rot;
  logic [2*NUM_REQ-1:0] w_oh_dbl;
  logic                 w_hit;

  // Rotate the request vector so the pointer position becomes bit 0.
  assign w_req_dbl = {i_req, i_req};
  assign w_req_rot = NUM_REQ'(w_req_dbl >> i_ptr);

  // Isolate the lowest set bit of the rotated vector (highest priority after the pointer).
  always_comb begin
    w_oh_rot = '0;
    w_hit    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_req_rot[k] && !w_hit) begin
        w_oh_rot[k] = 1'b1;
        w_hit       = 1'b1;
      end
    end
  end

  // Rotate the one-hot back into requester numbering.
  assign w_oh_dbl = {w_oh_rot, w_oh_rot} << i_ptr;
  assign o_grant  = NUM_REQ'(w_oh_dbl >> NUM_REQ);
  assign o_vld    = |i_req;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one four-phase memory port among NUM_REQ four-phase requesters.
// Latency: MEM_REQ 1 cycle after a request is sampled in IDLE; ACK_OUT 1 cycle after MEM_ACK falls.
// Backpressure: requesters wait (REQ held) until served; a stale or slow MEM_ACK stalls the FSM.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ           = 2,
  parameter int LC_MEM_DATA_WIDTH = 32,
  parameter int LC_MEM_ADDR_WIDTH = 32
) (
  input  logic                                     CLK,
  input  logic                                     RESET,
  input  logic [NUM_REQ-1:0]                       REQ_IN,
  input  logic [NUM_REQ-1:0]                       WRITE_IN,
  input  logic [NUM_REQ*(LC_MEM_ADDR_WIDTH-2)-1:0] ADDR_IN,
  input  logic [NUM_REQ*LC_MEM_DATA_WIDTH-1:0]     WDATA_IN,
  output logic [NUM_REQ-1:0]                       ACK_OUT,
  output logic [LC_MEM_DATA_WIDTH-1:0]             RDATA_OUT,
  output logic [NUM_REQ-1:0]                       GRANT_OUT,
  output logic [LC_MEM_ADDR_WIDTH-3:0]             MEM_ADDR,
  output logic [LC_MEM_DATA_WIDTH-1:0]             MEM_DATA,
  output logic                                     MEM_WRITE,
  output logic                                     MEM_REQ,
  input  logic [LC_MEM_DATA_WIDTH-1:0]             MEM_RDATA,
  input  logic                                     MEM_ACK
);

  localparam int AW = LC_MEM_ADDR_WIDTH - 2;
  localparam int DW = LC_MEM_DATA_WIDTH;
  localparam int PW = log2(NUM_REQ);

  state_t             r_state;
  logic [PW-1:0]      r_ptr;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_ack;
  logic [DW-1:0]      r_rdata;
  logic [AW-1:0]      r_mem_addr;
  logic [DW-1:0]      r_mem_data;
  logic               r_mem_write;
  logic               r_mem_req;

  logic [NUM_REQ-1:0] w_pick_grant;
  logic               w_pick_vld;
  logic [AW-1:0]      w_sel_addr;
  logic [DW-1:0]      w_sel_data;
  logic               w_sel_write;
  logic               w_grant_req;
  logic [PW-1:0]      w_next_ptr;

  mem_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PW)
  ) u_rr_pick (
    .i_req   (REQ_IN),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_vld   (w_pick_vld)
  );

  // Mux the picked requester's command out of the packed input buses.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_pick_grant[k]) begin
        w_sel_addr = ADDR_IN[k*AW +: AW];
        w_sel_data = WDATA_IN[k*DW +: DW];
      end
    end
  end

  assign w_sel_write = |(WRITE_IN & w_pick_grant);
  assign w_grant_req = |(REQ_IN & r_grant);

  // Pointer moves to the requester just after the current grant, wrapping to 0.
  always_comb begin
    w_next_ptr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_grant[k]) w_next_ptr = (k == NUM_REQ - 1) ? '0 : PW'(k + 1);
    end
  end

  // Arbitration FSM with all outputs registered; reset aborts any access in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_ack       <= '0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_mem_write <= 1'b0;
      r_mem_req   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // A MEM_ACK still high here is left over from before a local reset: hold off.
          if (w_pick_vld && !MEM_ACK) begin
            r_grant     <= w_pick_grant;
            r_mem_addr  <= w_sel_addr;
            r_mem_data  <= w_sel_data;
            r_mem_write <= w_sel_write;
            r_mem_req   <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (MEM_ACK) begin
            if (!r_mem_write) r_rdata <= MEM_RDATA;
            r_mem_req <= 1'b0;
            r_state   <= RELEASE;
          end
        end
        RELEASE: begin
          if (!MEM_ACK) begin
            r_ack   <= r_grant;
            r_state <= RESPOND;
          end
        end
        RESPOND: begin
          if (!w_grant_req) begin
            r_ack   <= '0;
            r_grant <= '0;
            r_ptr   <= w_next_ptr;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ACK_OUT   = r_ack;
  assign RDATA_OUT = r_rdata;
  assign GRANT_OUT = r_grant;
  assign MEM_ADDR  = r_mem_addr;
  assign MEM_DATA  = r_mem_data;
  assign MEM_WRITE = r_mem_write;
  assign MEM_REQ   = r_mem_req;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized concurrent requesters.
// A behavioural memory answers the four-phase port; a round-robin model predicts every grant.
// Read data is predicted from a reference memory updated as writes are acknowledged.
module tb_mem_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 30;
  localparam int IW = $clog2(N);
  typedef logic [IW-1:0] idx_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_in, write_in;
  logic [N*AW-1:0] addr_in;
  logic [N*DW-1:0] wdata_in;
  logic [N-1:0]    ack_out, grant_out;
  logic [DW-1:0]   rdata_out, mem_data, mem_rdata;
  logic [AW-1:0]   mem_addr;
  logic            mem_write, mem_req, mem_ack;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] mem_store [logic [AW-1:0]];
  logic [DW-1:0] ref_mem   [logic [AW-1:0]];
  logic          mem_auto      = 1'b1;
  logic          mem_ack_force = 1'b0;
  int            mem_dly       = 0;

  logic [AW-1:0] cmd_addr [N];
  logic [DW-1:0] cmd_wd   [N];
  logic          cmd_wr   [N];
  logic [N-1:0]  grant_q  [$];

  always #5 clk = ~clk;

  mem_arbiter #(
    .NUM_REQ           (N),
    .LC_MEM_DATA_WIDTH (DW),
    .LC_MEM_ADDR_WIDTH (AW + 2)
  ) dut (
    .CLK       (clk),
    .RESET     (rst),
    .REQ_IN    (req_in),
    .WRITE_IN  (write_in),
    .ADDR_IN   (addr_in),
    .WDATA_IN  (wdata_in),
    .ACK_OUT   (ack_out),
    .RDATA_OUT (rdata_out),
    .GRANT_OUT (grant_out),
    .MEM_ADDR  (mem_addr),
    .MEM_DATA  (mem_data),
    .MEM_WRITE (mem_write),
    .MEM_REQ   (mem_req),
    .MEM_RDATA (mem_rdata),
    .MEM_ACK   (mem_ack)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  // Contents of never-written words.
  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return 32'hA5A5_0000 ^ {2'b00, a};
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_cmd(input idx_t i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_addr[i]          = a;
    cmd_wd[i]            = d;
    cmd_wr[i]            = wr;
    addr_in[i*AW +: AW]  = a;
    wdata_in[i*DW +: DW] = d;
    write_in[i]          = wr;
  endtask

  // Behavioural memory: four-phase slave with 0..3 cycle random response delays.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!mem_auto) begin
        mem_ack = mem_ack_force;
        mem_dly = 0;
      end else if (!mem_ack) begin
        if (mem_req) begin
          if (mem_dly == 0) begin
            if (mem_write) mem_store[mem_addr] = mem_data;
            else mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : dflt(mem_addr);
            mem_ack = 1'b1;
            mem_dly = $urandom_range(0, 3);
          end else mem_dly--;
        end
      end else if (!mem_req) begin
        if (mem_dly == 0) begin
          mem_ack = 1'b0;
          mem_dly = $urandom_range(0, 3);
        end else mem_dly--;
      end
    end
  end

  // Round-robin reference: each new grant must be the first requester from the pointer upward.
  initial begin
    logic [N-1:0] prev_g;
    logic [N-1:0] exp_g;
    int ptr_m, cur, e, idx;
    prev_g = '0;
    ptr_m  = 0;
    cur    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        ptr_m  = 0;
        prev_g = '0;
      end else begin
        if (prev_g == '0 && grant_out != '0) begin
          e = -1;
          for (int k = 0; k < N; k++) begin
            idx = (ptr_m + k) % N;
            if (e < 0 && req_in[idx_t'(idx)]) e = idx;
          end
          exp_g = (e < 0) ? '0 : (N'(1) << e);
          check("rr_grant", 64'(grant_out), 64'(exp_g));
          if (e >= 0) begin
            check("mem_req_at_grant", 64'(mem_req), 64'(1));
            check("mem_addr", 64'(mem_addr), 64'(cmd_addr[idx_t'(e)]));
            check("mem_write", 64'(mem_write), 64'(cmd_wr[idx_t'(e)]));
            if (cmd_wr[idx_t'(e)]) check("mem_data", 64'(mem_data), 64'(cmd_wd[idx_t'(e)]));
          end
          cur = (e < 0) ? 0 : e;
          grant_q.push_back(grant_out);
        end
        if (prev_g != '0 && grant_out == '0) ptr_m = (cur + 1) % N;
        prev_g = grant_out;
      end
    end
  end

  // One four-phase transaction; scrambles its own inputs once granted; early=drop REQ right after grant.
  task automatic xact(input idx_t i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic early, input logic solo);
    int   n, rel_n;
    logic got, saw, rel;
    n = 0; rel_n = 0; got = 1'b0; saw = 1'b0; rel = 1'b0;
    set_cmd(i, wr, a, d);
    req_in[i] = 1'b1;
    while (n < 300 && !got) begin
      step();
      if (solo && n == 0) begin
        check("mem_req_latency", 64'(mem_req), 64'(1));
        check("grant_solo", 64'(grant_out), 64'(N'(1) << i));
      end
      if (ack_out[i]) begin
        got = 1'b1;
        if (rel) check("ack_latency", 64'(n - rel_n), 64'(1));
      end else if (grant_out[i]) begin
        if (mem_ack) saw = 1'b1;
        else if (saw && !rel) begin
          rel   = 1'b1;
          rel_n = n;
        end
        addr_in[i*AW +: AW]  = AW'($urandom);
        wdata_in[i*DW +: DW] = $urandom;
        write_in[i]          = 1'($urandom_range(0, 1));
        if (early) req_in[i] = 1'b0;
      end
      n++;
    end
    check("ack_seen", 64'(got), 64'(1));
    if (got) begin
      check("ack_onehot", 64'(ack_out), 64'(N'(1) << i));
      if (!wr) check("rdata", 64'(rdata_out), 64'(ref_rd(a)));
      else ref_mem[a] = d;
    end
    req_in[i] = 1'b0;
    step();
    check("ack_clear", 64'(ack_out[i]), 64'(0));
    check("grant_clear", 64'(grant_out[i]), 64'(0));
  endtask

  task automatic agent(input idx_t i, input int cnt);
    repeat (cnt) begin
      repeat ($urandom_range(0, 3)) step();
      xact(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 3) == 0), 1'b0);
    end
  endtask

  task automatic do_reset();
    req_in = '0;
    rst    = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, %0d vectors, %0d miscompares", vectors, miscompares);
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    req_in   = '0;
    write_in = '0;
    addr_in  = '0;
    wdata_in = '0;
    mem_store[30'h10] = 32'hDEAD_BEEF;
    ref_mem[30'h10]   = 32'hDEAD_BEEF;
    step();
    step();
    check("rst_ack", 64'(ack_out), 64'(0));
    check("rst_grant", 64'(grant_out), 64'(0));
    check("rst_rdata", 64'(rdata_out), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_data", 64'(mem_data), 64'(0));
    check("rst_mem_write", 64'(mem_write), 64'(0));
    check("rst_mem_req", 64'(mem_req), 64'(0));
    rst = 1'b0;
    step();

    // Single read from requester 0.
    xact(0, 1'b0, 30'h10, 32'h0, 1'b0, 1'b1);
    check("single_read", 64'(rdata_out), 64'(32'hDEAD_BEEF));

    // Requester 1 writes then reads back; the write leaves RDATA_OUT untouched.
    xact(1, 1'b1, 30'h20, 32'h1234_5678, 1'b0, 1'b1);
    check("rdata_hold_on_write", 64'(rdata_out), 64'(32'hDEAD_BEEF));
    xact(1, 1'b0, 30'h20, 32'h0, 1'b0, 1'b1);
    check("write_then_read", 64'(rdata_out), 64'(32'h1234_5678));

    // Contention from a fresh pointer: grants must alternate starting with requester 0.
    do_reset();
    grant_q.delete();
    fork
      begin
        xact(0, 1'b0, 30'h1, 32'h0, 1'b0, 1'b0);
        xact(0, 1'b1, 30'h2, 32'h0BAD_F00D, 1'b0, 1'b0);
      end
      begin
        xact(1, 1'b1, 30'h3, 32'h7777_1111, 1'b0, 1'b0);
        xact(1, 1'b0, 30'h3, 32'h0, 1'b0, 1'b0);
      end
    join
    check("contend_count", 64'(grant_q.size()), 64'(4));
    for (int k = 0; k < 4; k++)
      if (k < grant_q.size()) check("contend_order", 64'(grant_q[k]), 64'((k % 2 == 0) ? 2'b01 : 2'b10));

    // Requester 0 withdraws right after grant; requester 1 is pending and served next.
    do_reset();
    grant_q.delete();
    fork
      xact(0, 1'b0, 30'h10, 32'h0, 1'b1, 1'b0);
      begin
        step();
        xact(1, 1'b1, 30'h5, 32'hCAFE_0001, 1'b0, 1'b0);
      end
    join
    check("withdraw_count", 64'(grant_q.size()), 64'(2));
    if (grant_q.size() == 2) begin
      check("withdraw_first", 64'(grant_q[0]), 64'(2'b01));
      check("withdraw_next", 64'(grant_q[1]), 64'(2'b10));
    end

    // Reset during ISSUE, then a stale MEM_ACK must hold off the next issue.
    mem_auto      = 1'b0;
    mem_ack_force = 1'b0;
    step();
    set_cmd(0, 1'b0, 30'h10, 32'h0);
    req_in[0] = 1'b1;
    step();
    check("midop_in_issue", 64'(mem_req), 64'(1));
    rst           = 1'b1;
    mem_ack_force = 1'b1;
    #1;
    check("midop_mem_req", 64'(mem_req), 64'(0));
    check("midop_grant", 64'(grant_out), 64'(0));
    check("midop_ack", 64'(ack_out), 64'(0));
    check("midop_mem_addr", 64'(mem_addr), 64'(0));
    step();
    rst = 1'b0;
    repeat (3) begin
      step();
      check("stale_ack_block", 64'(mem_req), 64'(0));
      check("stale_ack_grant", 64'(grant_out), 64'(0));
    end
    req_in[0]     = 1'b0;
    mem_ack_force = 1'b0;
    step();
    mem_auto = 1'b1;
    step();
    xact(0, 1'b0, 30'h10, 32'h0, 1'b0, 1'b1);

    // Randomized concurrent traffic over a small address window.
    fork
      agent(0, 25);
      agent(1, 25);
    join

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
